pipelined_cla_addsub: RTL and testbench

PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

---
 rtl/pipelined_cla_addsub.sv | 134 +++++++++++++
 tb/tb_pipelined_cla_addsub.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one 4-bit lookahead group per stage,
// valid/ready handshake with whole-pipe stall on output backpressure.
`timescale 1ns/1ps
module pipelined_cla_addsub #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NGRP = WIDTH / 4;
    localparam int unsigned MSB  = WIDTH - 1;

    // Stage k holds the operands entering group k, the carry into it and the finished lower sum bits
    logic [NGRP-1:0]  vld_q, vld_d;
    logic [NGRP-1:0]  cy_q, cy_d;
    logic [WIDTH-1:0] opa_q  [NGRP];
    logic [WIDTH-1:0] opa_d  [NGRP];
    logic [WIDTH-1:0] opb_q  [NGRP];
    logic [WIDTH-1:0] opb_d  [NGRP];
    logic [WIDTH-1:0] psum_q [NGRP];
    logic [WIDTH-1:0] psum_d [NGRP];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             adv_c;
    logic [3:0]       grp_sum_c [NGRP];
    logic [NGRP-1:0]  grp_cout_c;

    // Fully expanded 4-bit lookahead; returns {carry_out, sum[3:0]}
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], p ^ c[3:0]};
    endfunction

    always_comb begin
        adv_c = !(out_valid_q && !out_ready);
        for (int unsigned k = 0; k < NGRP; k++) begin
            {grp_cout_c[k], grp_sum_c[k]} = cla4(opa_q[k][4*k +: 4], opb_q[k][4*k +: 4], cy_q[k]);
        end
    end

    assign in_ready = adv_c;

    always_comb begin
        vld_d       = vld_q;
        cy_d        = cy_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        psum_d      = psum_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        if (adv_c) begin
            vld_d[0]  = in_valid;
            opa_d[0]  = a;
            opb_d[0]  = sub ? ~b : b;
            cy_d[0]   = sub | cin;
            psum_d[0] = '0;
            for (int unsigned k = 1; k < NGRP; k++) begin
                vld_d[k]                  = vld_q[k-1];
                opa_d[k]                  = opa_q[k-1];
                opb_d[k]                  = opb_q[k-1];
                cy_d[k]                   = grp_cout_c[k-1];
                psum_d[k]                 = psum_q[k-1];
                psum_d[k][4*(k-1) +: 4]   = grp_sum_c[k-1];
            end
            out_valid_d      = vld_q[NGRP-1];
            sum_d            = psum_q[NGRP-1];
            sum_d[MSB -: 4]  = grp_sum_c[NGRP-1];
            cout_d           = grp_cout_c[NGRP-1];
            ovf_d            = (opa_q[NGRP-1][MSB] == opb_q[NGRP-1][MSB])
                            && (grp_sum_c[NGRP-1][3] != opa_q[NGRP-1][MSB]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            cy_q        <= '0;
            for (int unsigned k = 0; k < NGRP; k++) begin
                opa_q[k]  <= '0;
                opb_q[k]  <= '0;
                psum_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            cy_q        <= cy_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            psum_q      <= psum_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: directed 16-bit vectors, stall/reset scenarios,
// then concurrent random traffic on 4/8/32/64-bit instances against a reference model.
`timescale 1ns/1ps
module tb_pipelined_cla_addsub;

    localparam int unsigned NRND = 2500;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;
    logic        rnd_go = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_cla_addsub #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: returns {ovf, cout, sum zero-extended to 64 bits}
    function automatic logic [65:0] model(input int unsigned w, input logic [63:0] x,
                                          input logic [63:0] y, input logic ci, input logic sb);
        logic [64:0] mask, xe, ye, full;
        logic        c0;
        mask = (65'd1 << w) - 65'd1;
        xe   = {1'b0, x} & mask;
        ye   = sb ? (~{1'b0, y} & mask) : ({1'b0, y} & mask);
        c0   = sb | ci;
        full = xe + ye + 65'(c0);
        return {(xe[w-1] == ye[w-1]) && (full[w-1] != xe[w-1]), full[w], full[63:0] & mask[63:0]};
    endfunction

    task automatic do_one(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                          input logic xc, input logic xs, input logic [15:0] es,
                          input logic ec, input logic eo);
        int e_edge;
        int guard;
        @(negedge clk);
        a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check_eq({tag, "_rdy"}, 66'(in_ready), 66'(1));
        e_edge = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_eq({tag, "_lat"}, 66'(cyc - e_edge), 66'(4));
        check_eq({tag, "_sum"}, 66'(sum), 66'(es));
        check_eq({tag, "_cout"}, 66'(cout), 66'(ec));
        check_eq({tag, "_ovf"}, 66'(ovf), 66'(eo));
    endtask

    task automatic run_stream();
        logic [65:0] exp [10];
        logic [15:0] sa [10];
        logic [15:0] sb [10];
        int si, ri, t;
        for (int i = 0; i < 10; i++) begin
            sa[i]  = 16'(32'h1357 * 32'(i + 1));
            sb[i]  = 16'(32'h0F0F + 32'(4099 * i));
            exp[i] = model(16, 64'(sa[i]), 64'(sb[i]), 1'(i), 1'(i >> 1));
        end
        si = 0; ri = 0; t = 0;
        while (ri < 10 && t < 80) begin
            @(negedge clk);
            out_ready = !(t >= 7 && t <= 9);
            if (si < 10) begin
                a = sa[si]; b = sb[si]; cin = 1'(si); sub = 1'(si >> 1); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready) begin
                check_eq("stall_rdy", 66'(in_ready), 66'(0));
                check_eq("stall_vld", 66'(out_valid), 66'(1));
                check_eq("stall_hold", {ovf, cout, 64'(sum)}, exp[ri]);
            end
            if (in_valid && in_ready) si++;
            if (out_valid && out_ready) begin
                check_eq($sformatf("stream_%0d", ri), {ovf, cout, 64'(sum)}, exp[ri]);
                ri++;
            end
            t++;
        end
        in_valid = 1'b0;
        check_eq("stream_count", 66'(ri), 66'(10));
        @(negedge clk);
        #1;
        check_eq("stream_drained", 66'(out_valid), 66'(0));
    endtask

    task automatic run_reset_flush();
        int guard;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 16'(16'h0101 * i); b = 16'h0011; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_eq("flush_pre_vld", 66'(out_valid), 66'(1));
        rst_n = 1'b0;
        #1;
        check_eq("flush_vld", 66'(out_valid), 66'(0));
        check_eq("flush_sum", 66'(sum), 66'(0));
        check_eq("flush_cout", 66'(cout), 66'(0));
        check_eq("flush_ovf", 66'(ovf), 66'(0));
        check_eq("flush_rdy", 66'(in_ready), 66'(1));
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            check_eq("flush_stale", 66'(out_valid), 66'(0));
        end
        do_one("post_rst", 16'h00F0, 16'h0F10, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    endtask

    // Random traffic on the other legal widths, each with its own scoreboard
    for (genvar gi = 0; gi < 4; gi++) begin : g_rnd
        localparam int unsigned W = (gi == 0) ? 4 : (gi == 1) ? 8 : (gi == 2) ? 32 : 64;
        logic         iv, ir, ci, sb, ov, ordy, co, of, done;
        logic [W-1:0] ra, rb, rs;
        logic [65:0]  q [$];

        pipelined_cla_addsub #(.WIDTH(W)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
            .a(ra), .b(rb), .cin(ci), .sub(sb), .out_valid(ov),
            .out_ready(ordy), .sum(rs), .cout(co), .ovf(of)
        );

        initial begin
            logic fired;
            int   sent, got, guard;
            iv = 1'b0; ordy = 1'b0; ci = 1'b0; sb = 1'b0; ra = '0; rb = '0;
            done = 1'b0; fired = 1'b0; sent = 0; got = 0; guard = 0;
            wait (rnd_go);
            while (got < int'(NRND) && guard < int'(NRND) * 20) begin
                @(negedge clk);
                if (!iv || fired) begin
                    iv = (sent < int'(NRND)) && ($urandom_range(0, 3) != 0);
                    ra = W'({$urandom(), $urandom()});
                    rb = W'({$urandom(), $urandom()});
                    ci = 1'($urandom());
                    sb = 1'($urandom());
                end
                ordy = ($urandom_range(0, 3) != 0);
                #1;
                fired = iv && ir;
                if (ov && ordy) begin
                    if (q.size() == 0) begin
                        check_eq($sformatf("rnd_w%0d_spurious", W), 66'(1), 66'(0));
                    end else begin
                        check_eq($sformatf("rnd_w%0d", W), {of, co, 64'(rs)}, q.pop_front());
                    end
                    got++;
                end
                if (fired) begin
                    q.push_back(model(W, 64'(ra), 64'(rb), ci, sb));
                    sent++;
                end
                guard++;
            end
            iv = 1'b0;
            check_eq($sformatf("rnd_w%0d_count", W), 66'(got), 66'(NRND));
            done = 1'b1;
        end
    end

    initial begin
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_vld", 66'(out_valid), 66'(0));
        check_eq("rst_sum", 66'(sum), 66'(0));
        check_eq("rst_cout", 66'(cout), 66'(0));
        check_eq("rst_ovf", 66'(ovf), 66'(0));
        check_eq("rst_rdy", 66'(in_ready), 66'(1));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        do_one("add_cin",   16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
        do_one("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_one("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_one("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_one("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        do_one("sub_zero",  16'h1000, 16'h1000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        do_one("add_only_c",16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);

        run_stream();
        run_reset_flush();

        rnd_go = 1'b1;
        wait (g_rnd[0].done && g_rnd[1].done && g_rnd[2].done && g_rnd[3].done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
